serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first.
// A start accepted in idle latches the operands, WIDTH run cycles walk the
// borrow chain, and one done cycle presents the registered result.
module serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             bo,
  output logic             ov
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              br_q, br_d;
  logic              bo_q, bo_d;
  logic              ov_q, ov_d;
  logic              last_bit;
  logic              diff_bit;
  logic              br_next;

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // One full-subtractor cell; the operand shift registers present the
  // current bit at position 0.
  assign diff_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StRun:   busy = 1'b1;
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Datapath next-state: latch on accept, shift during run, publish on last bit
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    out_d = out_q;
    cnt_d = cnt_q;
    br_d  = br_q;
    bo_d  = bo_q;
    ov_d  = ov_q;
    if (state_q == StIdle && start) begin
      a_d   = a;
      b_d   = b;
      br_d  = bin;
      res_d = '0;
      cnt_d = '0;
    end else if (state_q == StRun) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = br_next;
      res_d = {diff_bit, res_q[WIDTH-1:1]};
      cnt_d = last_bit ? '0 : cnt_q + CntW'(1);
      if (last_bit) begin
        // On the last bit a_q[0]/b_q[0] hold the original operand MSBs.
        out_d = {diff_bit, res_q[WIDTH-1:1]};
        bo_d  = br_next;
        ov_d  = (a_q[0] != b_q[0]) && (diff_bit != a_q[0]);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
      br_q  <= 1'b0;
      bo_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
      br_q  <= br_d;
      bo_q  <= bo_d;
      ov_q  <= ov_d;
    end
  end

  assign out = out_q;
  assign bo  = bo_q;
  assign ov  = ov_q;

endmodule
